// File: rtl/dec_stage_rv32i.sv
// dec_stage_rv32i: RV32I decode stage behind a registered valid/ready slot with flush.
// Turns an instruction word into the ALU/LSU/branch control bundle.
// Optional feature macro: DEC_SKID_EN (2-entry skid buffer, registered readyOut).
// Without DEC_SKID_EN a single output register is used and readyOut is combinational.
module dec_stage_rv32i #(
  parameter int unsigned INT32W = 32,
  parameter int unsigned OPW    = 4
) (
  input  logic              clkIn,
  input  logic              rstNIn,
  input  logic [31:0]       instrIn,
  input  logic [INT32W-1:0] pcIn,
  input  logic              validIn,
  output logic              readyOut,
  input  logic              flushIn,
  input  logic              readyIn,
  output logic              validOut,
  output logic [OPW-1:0]    opTypeOut,
  output logic              negOp2Out,
  output logic [1:0]        op1SelOut,
  output logic              useImmOut,
  output logic [INT32W-1:0] immOut,
  output logic [4:0]        rs1Out,
  output logic [4:0]        rs2Out,
  output logic [4:0]        rdOut,
  output logic              rdWeOut,
  output logic              memRdOut,
  output logic              memWrOut,
  output logic              branchOut,
  output logic              jumpOut,
  output logic [2:0]        funct3Out,
  output logic [INT32W-1:0] pcOut,
  output logic              illegalOut
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;

  // ALU operation codes shared with the integer ALU
  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_AND = OPW'(1);
  localparam logic [OPW-1:0] OP_ORR = OPW'(2);
  localparam logic [OPW-1:0] OP_XOR = OPW'(3);
  localparam logic [OPW-1:0] OP_SLL = OPW'(4);
  localparam logic [OPW-1:0] OP_SRL = OPW'(5);
  localparam logic [OPW-1:0] OP_SRA = OPW'(6);
  localparam logic [OPW-1:0] OP_SLT = OPW'(7);
  localparam logic [OPW-1:0] OP_SLU = OPW'(8);

  localparam logic [SEL_W-1:0] SEL_RS1  = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_PC   = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_ZERO = SEL_W'(2);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [OPW-1:0]    op_type;
    logic              neg_op2;
    logic [SEL_W-1:0]  op1_sel;
    logic              use_imm;
    logic [INT32W-1:0] imm;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic              rd_we;
    logic              mem_rd;
    logic              mem_wr;
    logic              branch;
    logic              jump;
    logic [2:0]        funct3;
    logic [INT32W-1:0] pc;
    logic              illegal;
  } dec_bundle_t;

  logic [6:0]        w_opcode;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [INT32W-1:0] w_imm_i;
  logic [INT32W-1:0] w_imm_s;
  logic [INT32W-1:0] w_imm_b;
  logic [INT32W-1:0] w_imm_u;
  logic [INT32W-1:0] w_imm_j;
  logic [OPW-1:0]    w_alu_op;
  logic              w_ill;
  dec_bundle_t       w_dec;
  logic              w_out_free;
  logic              w_accept;

  dec_bundle_t       r_bundle;
  logic              r_valid;

  assign w_opcode = instrIn[6:0];
  assign w_f3     = instrIn[14:12];
  assign w_f7     = instrIn[31:25];

  // Immediate formats, all sign-extended from instr[31]
  assign w_imm_i = {{20{instrIn[31]}}, instrIn[31:20]};
  assign w_imm_s = {{20{instrIn[31]}}, instrIn[31:25], instrIn[11:7]};
  assign w_imm_b = {{19{instrIn[31]}}, instrIn[31], instrIn[7], instrIn[30:25],
                    instrIn[11:8], 1'b0};
  assign w_imm_u = {instrIn[31:12], 12'b0};
  assign w_imm_j = {{11{instrIn[31]}}, instrIn[31], instrIn[19:12], instrIn[20],
                    instrIn[30:21], 1'b0};

  // funct3 to ALU operation; funct7 only distinguishes SRA from SRL here
  always_comb begin
    w_alu_op = OP_ADD;
    case (w_f3)
      3'b000:  w_alu_op = OP_ADD;
      3'b001:  w_alu_op = OP_SLL;
      3'b010:  w_alu_op = OP_SLT;
      3'b011:  w_alu_op = OP_SLU;
      3'b100:  w_alu_op = OP_XOR;
      3'b101:  w_alu_op = (w_f7 == F7_ALT) ? OP_SRA : OP_SRL;
      3'b110:  w_alu_op = OP_ORR;
      default: w_alu_op = OP_AND;
    endcase
  end

  // Opcode decode into the control bundle; illegal encodings lose all side effects
  always_comb begin
    w_dec        = '0;
    w_ill        = 1'b0;
    w_dec.rs1    = instrIn[19:15];
    w_dec.rs2    = instrIn[24:20];
    w_dec.rd     = instrIn[11:7];
    w_dec.funct3 = w_f3;
    w_dec.pc     = pcIn;
    w_dec.op_type = OP_ADD;
    case (w_opcode)
      OPC_LUI: begin
        w_dec.op1_sel = SEL_ZERO;
        w_dec.use_imm = 1'b1;
        w_dec.imm     = w_imm_u;
        w_dec.rd_we   = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec.op1_sel = SEL_PC;
        w_dec.use_imm = 1'b1;
        w_dec.imm     = w_imm_u;
        w_dec.rd_we   = 1'b1;
      end
      OPC_JAL: begin
        w_dec.op1_sel = SEL_PC;
        w_dec.use_imm = 1'b1;
        w_dec.imm     = w_imm_j;
        w_dec.rd_we   = 1'b1;
        w_dec.jump    = 1'b1;
      end
      OPC_JALR: begin
        w_dec.op1_sel = SEL_RS1;
        w_dec.use_imm = 1'b1;
        w_dec.imm     = w_imm_i;
        w_dec.rd_we   = 1'b1;
        w_dec.jump    = 1'b1;
        w_ill         = (w_f3 != 3'b000);
      end
      OPC_BRANCH: begin
        w_dec.op1_sel = SEL_PC;
        w_dec.use_imm = 1'b1;
        w_dec.imm     = w_imm_b;
        w_dec.branch  = 1'b1;
        w_ill         = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      OPC_LOAD: begin
        w_dec.use_imm = 1'b1;
        w_dec.imm     = w_imm_i;
        w_dec.rd_we   = 1'b1;
        w_dec.mem_rd  = 1'b1;
      end
      OPC_STORE: begin
        w_dec.use_imm = 1'b1;
        w_dec.imm     = w_imm_s;
        w_dec.mem_wr  = 1'b1;
      end
      OPC_OPIMM: begin
        w_dec.use_imm = 1'b1;
        w_dec.imm     = w_imm_i;
        w_dec.op_type = w_alu_op;
        w_dec.rd_we   = 1'b1;
        // Shift-immediates reuse imm[11:5] as a funct7 field
        if (w_f3 == 3'b001) begin
          w_ill = (w_f7 != F7_ZERO);
        end else if (w_f3 == 3'b101) begin
          w_ill = (w_f7 != F7_ZERO) && (w_f7 != F7_ALT);
        end
      end
      OPC_OP: begin
        w_dec.op_type = w_alu_op;
        w_dec.neg_op2 = (w_f3 == 3'b000) && (w_f7 == F7_ALT);
        w_dec.rd_we   = 1'b1;
        w_ill = !((w_f7 == F7_ZERO) ||
                  ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
      end
      OPC_FENCE: begin
        w_dec.op_type = OP_ADD;
      end
      default: begin
        w_ill = 1'b1;
      end
    endcase
    if (w_dec.rd == REG_W'(0)) begin
      w_dec.rd_we = 1'b0;
    end
    if (w_ill) begin
      w_dec.rd_we  = 1'b0;
      w_dec.mem_rd = 1'b0;
      w_dec.mem_wr = 1'b0;
      w_dec.branch = 1'b0;
      w_dec.jump   = 1'b0;
    end
    w_dec.illegal = w_ill;
  end

  assign w_out_free = !r_valid || readyIn;

`ifdef DEC_SKID_EN
  dec_bundle_t r_skid;
  logic        r_skid_valid;
  logic        r_ready;

  assign readyOut = r_ready;
  assign w_accept = validIn && r_ready;

  // Output slot plus one skid entry; skid drains first to keep ordering
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      r_valid      <= 1'b0;
      r_bundle     <= '0;
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
      r_ready      <= 1'b1;
    end else if (flushIn) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_valid      <= 1'b1;
        r_bundle     <= r_skid;
        r_skid_valid <= 1'b0;
        r_ready      <= 1'b1;
      end else if (w_accept) begin
        r_valid  <= 1'b1;
        r_bundle <= w_dec;
      end else begin
        r_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
      r_ready      <= 1'b0;
    end
  end
`else
  assign readyOut = w_out_free;
  assign w_accept = validIn && w_out_free;

  // Single output register: load on accept, drain on consume, hold on stall
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      r_valid  <= 1'b0;
      r_bundle <= '0;
    end else if (flushIn) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_bundle <= w_dec;
    end else if (readyIn) begin
      r_valid <= 1'b0;
    end
  end
`endif

  assign validOut   = r_valid;
  assign opTypeOut  = r_bundle.op_type;
  assign negOp2Out  = r_bundle.neg_op2;
  assign op1SelOut  = r_bundle.op1_sel;
  assign useImmOut  = r_bundle.use_imm;
  assign immOut     = r_bundle.imm;
  assign rs1Out     = r_bundle.rs1;
  assign rs2Out     = r_bundle.rs2;
  assign rdOut      = r_bundle.rd;
  assign rdWeOut    = r_bundle.rd_we;
  assign memRdOut   = r_bundle.mem_rd;
  assign memWrOut   = r_bundle.mem_wr;
  assign branchOut  = r_bundle.branch;
  assign jumpOut    = r_bundle.jump;
  assign funct3Out  = r_bundle.funct3;
  assign pcOut      = r_bundle.pc;
  assign illegalOut = r_bundle.illegal;

endmodule

// File: tb/tb_dec_stage_rv32i.sv
// Scoreboard bench for dec_stage_rv32i: directed instruction vectors with
// hand-decoded expectations, stall/hold, flush and asynchronous reset.
module tb_dec_stage_rv32i;

  localparam logic [3:0] T_ADD = 4'd0;
  localparam logic [3:0] T_XOR = 4'd3;
  localparam logic [3:0] T_SLL = 4'd4;
  localparam logic [3:0] T_SRA = 4'd6;
  localparam logic [3:0] T_SLU = 4'd8;
  localparam int N = 19;

  typedef struct packed {
    logic [3:0]  op;
    logic        neg;
    logic [1:0]  op1;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        br;
    logic        jmp;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  logic        clkIn, rstNIn, validIn, readyOut, flushIn, readyIn, validOut;
  logic [31:0] instrIn, pcIn, immOut, pcOut;
  logic [3:0]  opTypeOut;
  logic        negOp2Out, useImmOut, rdWeOut, memRdOut, memWrOut, branchOut, jumpOut, illegalOut;
  logic [1:0]  op1SelOut;
  logic [4:0]  rs1Out, rs2Out, rdOut;
  logic [2:0]  funct3Out;
  logic [95:0] act;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t  q[$];
  string qn[$];
  logic [31:0] v_ins [N];
  exp_t        v_exp [N];
  string       v_nm  [N];

  dec_stage_rv32i dut (
    .clkIn(clkIn), .rstNIn(rstNIn), .instrIn(instrIn), .pcIn(pcIn),
    .validIn(validIn), .readyOut(readyOut), .flushIn(flushIn), .readyIn(readyIn),
    .validOut(validOut), .opTypeOut(opTypeOut), .negOp2Out(negOp2Out),
    .op1SelOut(op1SelOut), .useImmOut(useImmOut), .immOut(immOut),
    .rs1Out(rs1Out), .rs2Out(rs2Out), .rdOut(rdOut), .rdWeOut(rdWeOut),
    .memRdOut(memRdOut), .memWrOut(memWrOut), .branchOut(branchOut),
    .jumpOut(jumpOut), .funct3Out(funct3Out), .pcOut(pcOut), .illegalOut(illegalOut)
  );

  assign act = {opTypeOut, negOp2Out, op1SelOut, useImmOut, immOut, rs1Out, rs2Out,
                rdOut, rdWeOut, memRdOut, memWrOut, branchOut, jumpOut, funct3Out,
                pcOut, illegalOut};

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  task automatic chk(input bit ok, input string nm, input logic [95:0] a, input logic [95:0] e);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask

  function automatic exp_t mk(input logic [3:0] op, input logic neg, input logic [1:0] op1,
                              input logic ui, input logic [31:0] imm, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd, input logic we,
                              input logic mr, input logic mw, input logic br, input logic j,
                              input logic [2:0] f3, input logic ill);
    exp_t e;
    e = '{op: op, neg: neg, op1: op1, use_imm: ui, imm: imm, rs1: rs1, rs2: rs2, rd: rd,
          rd_we: we, mem_rd: mr, mem_wr: mw, br: br, jmp: j, f3: f3, pc: 32'h0, ill: ill};
    return e;
  endfunction

  // Monitor: pop and compare on each output transfer; check hold during stalls
  logic [95:0] snap;
  bit          have_snap = 1'b0;
  always @(negedge clkIn) begin
    if (!rstNIn) begin
      have_snap = 1'b0;
    end else begin
      if (have_snap) chk(act == snap, "hold_stable", act, snap);
      if (validOut && readyIn && !flushIn) begin
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_output", act, 96'h0);
        end else begin
          exp_t  e;
          string nm;
          e  = q.pop_front();
          nm = qn.pop_front();
          chk(act == e, nm, act, e);
        end
      end
      have_snap = validOut && !readyIn && !flushIn;
      snap = act;
    end
  end

  task automatic send(input int idx, input logic [31:0] pc);
    bit   rdy;
    bit   done;
    exp_t e;
    done = 1'b0;
    instrIn = v_ins[idx];
    pcIn    = pc;
    validIn = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clkIn);
      rdy = readyOut && !flushIn;
      @(posedge clkIn);
      if (rdy) begin
        e = v_exp[idx];
        e.pc = pc;
        q.push_back(e);
        qn.push_back(v_nm[idx]);
        done = 1'b1;
      end
      #1;
    end
    if (!done) chk(1'b0, "accept_timeout", 96'h0, 96'h1);
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 30 && q.size() != 0; k++) @(negedge clkIn);
    chk(q.size() == 0, nm, 96'(q.size()), 96'h0);
    @(posedge clkIn);
    #1;
  endtask

  initial begin
    v_ins[0]  = 32'h00500093; v_nm[0]  = "addi";
    v_exp[0]  = mk(T_ADD,0,0,1,32'h5,        0, 5, 1, 1,0,0,0,0, 3'd0,0);
    v_ins[1]  = 32'h402081B3; v_nm[1]  = "sub";
    v_exp[1]  = mk(T_ADD,1,0,0,32'h0,        1, 2, 3, 1,0,0,0,0, 3'd0,0);
    v_ins[2]  = 32'h40335293; v_nm[2]  = "srai";
    v_exp[2]  = mk(T_SRA,0,0,1,32'h403,      6, 3, 5, 1,0,0,0,0, 3'd5,0);
    v_ins[3]  = 32'h123453B7; v_nm[3]  = "lui";
    v_exp[3]  = mk(T_ADD,0,2,1,32'h12345000, 8, 3, 7, 1,0,0,0,0, 3'd5,0);
    v_ins[4]  = 32'hFFFFFFFF; v_nm[4]  = "ill_ones";
    v_exp[4]  = mk(T_ADD,0,0,0,32'h0,       31,31,31, 0,0,0,0,0, 3'd7,1);
    v_ins[5]  = 32'h0020A423; v_nm[5]  = "sw";
    v_exp[5]  = mk(T_ADD,0,0,1,32'h8,        1, 2, 8, 0,0,1,0,0, 3'd2,0);
    v_ins[6]  = 32'hFE208EE3; v_nm[6]  = "beq_neg";
    v_exp[6]  = mk(T_ADD,0,1,1,32'hFFFFFFFC, 1, 2,29, 0,0,0,1,0, 3'd0,0);
    v_ins[7]  = 32'h008000EF; v_nm[7]  = "jal";
    v_exp[7]  = mk(T_ADD,0,1,1,32'h8,        0, 8, 1, 1,0,0,0,1, 3'd0,0);
    v_ins[8]  = 32'hFFF12203; v_nm[8]  = "lw_neg";
    v_exp[8]  = mk(T_ADD,0,0,1,32'hFFFFFFFF, 2,31, 4, 1,1,0,0,0, 3'd2,0);
    v_ins[9]  = 32'h00000013; v_nm[9]  = "nop_rd0";
    v_exp[9]  = mk(T_ADD,0,0,1,32'h0,        0, 0, 0, 0,0,0,0,0, 3'd0,0);
    v_ins[10] = 32'h020000B3; v_nm[10] = "ill_op_f7";
    v_exp[10] = mk(T_ADD,0,0,0,32'h0,        0, 0, 1, 0,0,0,0,0, 3'd0,1);
    v_ins[11] = 32'h40109093; v_nm[11] = "ill_slli";
    v_exp[11] = mk(T_SLL,0,0,1,32'h401,      1, 1, 1, 0,0,0,0,0, 3'd1,1);
    v_ins[12] = 32'h0020C1B3; v_nm[12] = "xor";
    v_exp[12] = mk(T_XOR,0,0,0,32'h0,        1, 2, 3, 1,0,0,0,0, 3'd4,0);
    v_ins[13] = 32'hFFFFF297; v_nm[13] = "auipc";
    v_exp[13] = mk(T_ADD,0,1,1,32'hFFFFF000,31,31, 5, 1,0,0,0,0, 3'd7,0);
    v_ins[14] = 32'h00002063; v_nm[14] = "ill_branch_f3";
    v_exp[14] = mk(T_ADD,0,1,1,32'h0,        0, 0, 0, 0,0,0,0,0, 3'd2,1);
    v_ins[15] = 32'h0FF0000F; v_nm[15] = "fence";
    v_exp[15] = mk(T_ADD,0,0,0,32'h0,        0,31, 0, 0,0,0,0,0, 3'd0,0);
    v_ins[16] = 32'h004100E7; v_nm[16] = "jalr";
    v_exp[16] = mk(T_ADD,0,0,1,32'h4,        2, 4, 1, 1,0,0,0,1, 3'd0,0);
    v_ins[17] = 32'h403150B3; v_nm[17] = "sra";
    v_exp[17] = mk(T_SRA,0,0,0,32'h0,        2, 3, 1, 1,0,0,0,0, 3'd5,0);
    v_ins[18] = 32'hFFF0B093; v_nm[18] = "sltiu";
    v_exp[18] = mk(T_SLU,0,0,1,32'hFFFFFFFF, 1,31, 1, 1,0,0,0,0, 3'd3,0);

    rstNIn = 1'b0; validIn = 1'b0; flushIn = 1'b0; readyIn = 1'b0;
    instrIn = 32'h0; pcIn = 32'h0;

    // Reset state
    repeat (2) @(negedge clkIn);
    chk(validOut == 1'b0, "rst_valid", 96'(validOut), 96'h0);
    chk(act == 96'h0, "rst_payload", act, 96'h0);
    chk(readyOut == 1'b1, "rst_ready", 96'(readyOut), 96'h1);
    @(posedge clkIn); #1;
    rstNIn = 1'b1; readyIn = 1'b1;

    // Full-rate decode of every vector
    for (int i = 0; i < N; i++) send(i, 32'h1000 + 32'(4 * i));
    validIn = 1'b0;
    drain("drain_vectors");

    // Back-to-back with readyIn low for three cycles
    fork
      begin
        for (int i = 0; i < 4; i++) send(i, 32'h2000 + 32'(4 * i));
        validIn = 1'b0;
      end
      begin
        @(posedge clkIn); #1;
        readyIn = 1'b0;
        @(negedge clkIn);
`ifdef DEC_SKID_EN
        chk(readyOut == 1'b1, "ready_lag", 96'(readyOut), 96'h1);
`else
        chk(readyOut == 1'b0, "ready_comb", 96'(readyOut), 96'h0);
`endif
        @(posedge clkIn);
        @(negedge clkIn);
        chk(readyOut == 1'b0, "ready_stalled", 96'(readyOut), 96'h0);
        @(posedge clkIn);
        @(posedge clkIn); #1;
        readyIn = 1'b1;
      end
    join
    drain("drain_stall");

    // Flush with an instruction held and another presented
    send(4, 32'h3000);
    instrIn = v_ins[0]; pcIn = 32'h3004; validIn = 1'b1; flushIn = 1'b1;
    @(posedge clkIn); #1;
    flushIn = 1'b0; validIn = 1'b0;
    q.delete(); qn.delete();
    @(negedge clkIn);
    chk(validOut == 1'b0, "flush_valid", 96'(validOut), 96'h0);
    chk(readyOut == 1'b1, "flush_ready", 96'(readyOut), 96'h1);
    repeat (3) @(negedge clkIn);
    chk(validOut == 1'b0, "flush_no_ghost", 96'(validOut), 96'h0);
    @(posedge clkIn); #1;

    // Asynchronous reset while an instruction is held
    readyIn = 1'b0;
    send(6, 32'h4000);
    validIn = 1'b0;
    #3;
    rstNIn = 1'b0;
    #1;
    chk(validOut == 1'b0, "async_rst_valid", 96'(validOut), 96'h0);
    chk(act == 96'h0, "async_rst_payload", act, 96'h0);
    q.delete(); qn.delete();
    @(negedge clkIn);
    @(posedge clkIn); #1;
    rstNIn = 1'b1; readyIn = 1'b1;
    send(1, 32'h5000);
    validIn = 1'b0;
    drain("drain_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
